// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter for one master port of the stream crossbar.
// Optional per-source packet bursting is enabled by defining STREAM_RR_ARB_BURST_EN.
module stream_rr_arbiter #(
    parameter  int unsigned S_DATA_COUNT   = 4,
    parameter  int unsigned MAX_BURST_PKTS = 4,
    localparam int unsigned T_ID___WIDTH   = $clog2(S_DATA_COUNT)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [S_DATA_COUNT-1:0]   requests_mask_i,
    input  logic [S_DATA_COUNT-1:0]   last_i,
    input  logic                      xfer_i,
    output logic [S_DATA_COUNT-1:0]   grant_o,
    output logic [T_ID___WIDTH-1:0]   id_o,
    output logic                      grant_valid_o,
    output logic                      err_o
);

    if (S_DATA_COUNT < 2 || MAX_BURST_PKTS < 1) begin : g_param_check
        $error("stream_rr_arbiter: S_DATA_COUNT must be >= 2 and MAX_BURST_PKTS >= 1");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                    state;
    logic [T_ID___WIDTH-1:0]   ptr;
    logic [T_ID___WIDTH-1:0]   next_ptr;
    logic [T_ID___WIDTH-1:0]   scan_base;
    logic [2*S_DATA_COUNT-1:0] req_rot_full;
    logic [S_DATA_COUNT-1:0]   req_rot;
    logic [T_ID___WIDTH-1:0]   win_off;
    logic [T_ID___WIDTH:0]     win_sum;
    logic [T_ID___WIDTH-1:0]   winner;
    logic                      win_valid;
    logic [S_DATA_COUNT-1:0]   win_onehot;
    logic                      pkt_end;

`ifdef STREAM_RR_ARB_BURST_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST_PKTS) + 1;
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_retain;

    assign burst_retain = requests_mask_i[id_o] && (32'(burst_cnt) + 32'd1 < MAX_BURST_PKTS);
`endif

    assign pkt_end   = (state == LOCKED) && xfer_i && last_i[id_o];
    assign next_ptr  = (id_o == T_ID___WIDTH'(S_DATA_COUNT - 1)) ? '0 : id_o + 1'b1;
    // While locked, the scan already starts past the current source so a
    // packet end can hand over in the same cycle.
    assign scan_base = (state == LOCKED) ? next_ptr : ptr;

    // Rotating the doubled mask by the base turns the wrap-around scan into a
    // plain lowest-set-bit search that never exceeds S_DATA_COUNT-1.
    assign req_rot_full = {requests_mask_i, requests_mask_i} >> scan_base;
    assign req_rot      = req_rot_full[S_DATA_COUNT-1:0];

    always_comb begin
        win_valid = 1'b0;
        win_off   = '0;
        for (int unsigned k = 0; k < S_DATA_COUNT; k++) begin
            if (!win_valid && req_rot[k[T_ID___WIDTH-1:0]]) begin
                win_valid = 1'b1;
                win_off   = k[T_ID___WIDTH-1:0];
            end
        end
        win_sum = {1'b0, scan_base} + {1'b0, win_off};
        if (win_sum >= (T_ID___WIDTH + 1)'(S_DATA_COUNT)) begin
            win_sum = win_sum - (T_ID___WIDTH + 1)'(S_DATA_COUNT);
        end
        winner     = win_sum[T_ID___WIDTH-1:0];
        win_onehot = {{(S_DATA_COUNT - 1){1'b0}}, 1'b1} << winner;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ptr           <= '0;
            grant_o       <= '0;
            id_o          <= '0;
            grant_valid_o <= 1'b0;
            err_o         <= 1'b0;
`ifdef STREAM_RR_ARB_BURST_EN
            burst_cnt     <= '0;
`endif
        end else begin
            if (xfer_i && !grant_valid_o) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant_o       <= win_onehot;
                        id_o          <= winner;
                        grant_valid_o <= 1'b1;
                        state         <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (pkt_end) begin
`ifdef STREAM_RR_ARB_BURST_EN
                        if (burst_retain) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end else begin
                            burst_cnt <= '0;
`endif
                            ptr <= next_ptr;
                            if (win_valid) begin
                                grant_o <= win_onehot;
                                id_o    <= winner;
                            end else begin
                                grant_o       <= '0;
                                id_o          <= '0;
                                grant_valid_o <= 1'b0;
                                state         <= IDLE;
                            end
`ifdef STREAM_RR_ARB_BURST_EN
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
